sap_control_unit: RTL and testbench

- Combined timing, control and arithmetic core of the 8-bit SAP-1 style CPU.
- Gates the free-running input clock with the halt signal and distributes the gated clock to all datapath registers (PC, MAR/memory, IR, A, B).
- Runs a 6-stage microinstruction sequencer that decodes the IR opcode into a 12-bit control word.
- Contains the combinational add/subtract unit that drives the bus when `adder_en` is asserted.

---
 rtl/sap_pkg.sv | 27 ++
 rtl/sap_alu.sv | 13 +
 rtl/sap_control_unit.sv | 93 +++++++++
 tb/tb_sap_control_unit.sv | 133 +++++++++++++
 4 files changed

// File: rtl/sap_pkg.sv
// Shared constants for the SAP-1 control unit: opcodes, control-word bit
// positions and the microinstruction stage encoding.
package sap_pkg;

  localparam logic [3:0] OP_LDA = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_HLT = 4'hF;

  localparam int CTRL_HLT       = 11;
  localparam int CTRL_PC_INC    = 10;
  localparam int CTRL_PC_EN     = 9;
  localparam int CTRL_MAR_LOAD  = 8;
  localparam int CTRL_MEM_EN    = 7;
  localparam int CTRL_IR_LOAD   = 6;
  localparam int CTRL_IR_EN     = 5;
  localparam int CTRL_A_LOAD    = 4;
  localparam int CTRL_A_EN      = 3;
  localparam int CTRL_B_LOAD    = 2;
  localparam int CTRL_ADDER_SUB = 1;
  localparam int CTRL_ADDER_EN  = 0;

  localparam int NUM_STAGES = 6;

  typedef enum logic [2:0] {T0, T1, T2, T3, T4, T5} stage_t;

endpackage

// File: rtl/sap_alu.sv
// Combinational add/subtract unit; subtraction is a + ~b + 1.
module sap_alu #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic [WIDTH-1:0] sum
);

  assign sum = a + (sub ? ~b : b) + WIDTH'(sub);

endmodule

// File: rtl/sap_control_unit.sv
// SAP-1 timing/control core: halt clock gate, 6-stage sequencer, opcode
// decode into the control word, and the bus adder.
module sap_control_unit
  import sap_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  output logic             clk_out,
  input  logic [3:0]       opcode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] adder_out,
  output logic [11:0]      ctrl
);

  stage_t stage;

  // hlt only rises while clk is low (stage moves on the falling edge),
  // so the AND gate cannot produce a runt pulse.
  assign clk_out = clk & ~ctrl[CTRL_HLT];

  always_ff @(negedge clk_out or posedge rst) begin
    if (rst)
      stage <= T0;
    else if (int'(stage) >= NUM_STAGES - 1)
      stage <= T0;
    else
      stage <= stage_t'(stage + 3'd1);
  end

  always_comb begin
    ctrl = '0;
    case (stage)
      T0: begin
        ctrl[CTRL_PC_EN]    = 1'b1;
        ctrl[CTRL_MAR_LOAD] = 1'b1;
      end
      T1: ctrl[CTRL_PC_INC] = 1'b1;
      T2: begin
        ctrl[CTRL_MEM_EN]  = 1'b1;
        ctrl[CTRL_IR_LOAD] = 1'b1;
      end
      T3: begin
        case (opcode)
          OP_LDA, OP_ADD, OP_SUB: begin
            ctrl[CTRL_IR_EN]    = 1'b1;
            ctrl[CTRL_MAR_LOAD] = 1'b1;
          end
          OP_HLT: ctrl[CTRL_HLT] = 1'b1;
          default: ;
        endcase
      end
      T4: begin
        case (opcode)
          OP_LDA: begin
            ctrl[CTRL_MEM_EN] = 1'b1;
            ctrl[CTRL_A_LOAD] = 1'b1;
          end
          OP_ADD, OP_SUB: begin
            ctrl[CTRL_MEM_EN] = 1'b1;
            ctrl[CTRL_B_LOAD] = 1'b1;
          end
          default: ;
        endcase
      end
      T5: begin
        case (opcode)
          OP_ADD: begin
            ctrl[CTRL_ADDER_EN] = 1'b1;
            ctrl[CTRL_A_LOAD]   = 1'b1;
          end
          OP_SUB: begin
            ctrl[CTRL_ADDER_SUB] = 1'b1;
            ctrl[CTRL_ADDER_EN]  = 1'b1;
            ctrl[CTRL_A_LOAD]    = 1'b1;
          end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  sap_alu #(.WIDTH(WIDTH)) u_alu (
    .a   (a),
    .b   (b),
    .sub (ctrl[CTRL_ADDER_SUB]),
    .sum (adder_out)
  );

endmodule

// File: tb/tb_sap_control_unit.sv
// Directed bench for sap_control_unit: per-opcode control-word tables,
// adder results at T5, halt freeze, and asynchronous reset corner cases.
module tb_sap_control_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clk_out;
  logic [3:0]  opcode = 4'h0;
  logic [7:0]  a = 8'h00;
  logic [7:0]  b = 8'h00;
  logic [7:0]  adder_out;
  logic [11:0] ctrl;

  int checks = 0;
  int errors = 0;

  sap_control_unit #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .clk_out   (clk_out),
    .opcode    (opcode),
    .a         (a),
    .b         (b),
    .adder_out (adder_out),
    .ctrl      (ctrl)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [11:0] exp [6];
    logic [7:0]  exp_out;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_vec(input int i, input logic [3:0] op, input logic [7:0] va,
                         input logic [7:0] vb, input logic [11:0] c3,
                         input logic [11:0] c4, input logic [11:0] c5,
                         input logic [7:0] eo);
    vecs[i].op = op; vecs[i].a = va; vecs[i].b = vb;
    vecs[i].exp[0] = 12'h300; vecs[i].exp[1] = 12'h400; vecs[i].exp[2] = 12'h0C0;
    vecs[i].exp[3] = c3; vecs[i].exp[4] = c4; vecs[i].exp[5] = c5;
    vecs[i].exp_out = eo;
  endtask

  // Pulse reset while clk is high so the first falling edge after it is T0->T1.
  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    #1 rst = 1'b0;
    #1;
  endtask

  initial begin
    set_vec(0, 4'h0, 8'h1C, 8'h0E, 12'h120, 12'h090, 12'h000, 8'h2A);
    set_vec(1, 4'h1, 8'h1C, 8'h0E, 12'h120, 12'h084, 12'h011, 8'h2A);
    set_vec(2, 4'h2, 8'h1C, 8'h0E, 12'h120, 12'h084, 12'h013, 8'h0E);
    set_vec(3, 4'h1, 8'hFF, 8'h01, 12'h120, 12'h084, 12'h011, 8'h00);
    set_vec(4, 4'h2, 8'h00, 8'h01, 12'h120, 12'h084, 12'h013, 8'hFF);
    set_vec(5, 4'h7, 8'h05, 8'h03, 12'h000, 12'h000, 12'h000, 8'h08);

    #1;
    chk("reset_ctrl", 32'(ctrl), 32'h300);

    for (int i = 0; i < 6; i++) begin
      opcode = vecs[i].op; a = vecs[i].a; b = vecs[i].b;
      do_reset();
      for (int s = 0; s < 6; s++) begin
        chk($sformatf("v%0d_op%0h_T%0d", i, vecs[i].op, s), 32'(ctrl), 32'(vecs[i].exp[s]));
        if (s == 5)
          chk($sformatf("v%0d_adder_out", i), 32'(adder_out), 32'(vecs[i].exp_out));
        @(negedge clk); #1;
      end
      chk($sformatf("v%0d_wrap_T0", i), 32'(ctrl), 32'h300);
    end

    // Halt: stage freezes at T3 and clk_out stays low until reset.
    opcode = 4'hF;
    do_reset();
    repeat (3) @(negedge clk);
    #1;
    chk("hlt_T3_ctrl", 32'(ctrl), 32'h800);
    for (int c = 0; c < 22; c++) begin
      @(posedge clk); #1;
      chk($sformatf("hlt_clk_out_%0d", c), 32'(clk_out), 32'h0);
      chk($sformatf("hlt_frozen_%0d", c), 32'(ctrl), 32'h800);
    end
    rst = 1'b1;
    #1;
    chk("hlt_rst_ctrl", 32'(ctrl), 32'h300);
    chk("hlt_rst_clk_out_hi", 32'(clk_out), 32'h1);
    rst = 1'b0;
    @(negedge clk); #1;
    chk("hlt_rst_clk_out_lo", 32'(clk_out), 32'h0);
    chk("hlt_rst_T1", 32'(ctrl), 32'h400);
    @(posedge clk); #1;
    chk("hlt_rst_clk_out_toggle", 32'(clk_out), 32'h1);

    // Asynchronous reset while sitting in T4 of a NOP, clk low.
    opcode = 4'h7;
    do_reset();
    repeat (4) @(negedge clk);
    #1;
    chk("nop_T4", 32'(ctrl), 32'h000);
    #1 rst = 1'b1;
    #1;
    chk("async_rst_T4", 32'(ctrl), 32'h300);
    chk("async_rst_clk_low", 32'(clk), 32'h0);
    rst = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
